// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer for the multi-cycle MIPS datapath with a
// memory-ready handshake, a per-state wait timeout and a sticky fault state.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       InstrDone,
  output logic       Fault,
  output logic [1:0] FaultCause,
  output logic [3:0] State
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = TIMEOUT_CYCLES > 0 ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
    ADDIEX = 4'd10, ADDIWB = 4'd11, FAULT = 4'd15
  } state_t;
  state_t state, nextState;
  logic [1:0] cause, nextCause;
  logic [CW-1:0] waitCnt;
  logic memState, stalled, timedOut;
  assign memState = state == FETCH || state == MEMRD || state == MEMWR;
  assign stalled  = memState && !MemReady;
  // A ready on the boundary cycle wins because stalled requires MemReady=0.
  assign timedOut = TIMEOUT_CYCLES != 0 && stalled && waitCnt == LAST;
  always_comb begin
    nextState = state;
    case (state)
      FETCH:  nextState = MemReady ? DECODE : FETCH;
      DECODE: nextState = Opcode == OP_R ? EXEC :
                          (Opcode == OP_LW || Opcode == OP_SW) ? MEMADR :
                          Opcode == OP_BEQ ? BRANCH :
                          Opcode == OP_J ? JUMP :
                          Opcode == OP_ADDI ? ADDIEX : FAULT;
      MEMADR: nextState = Opcode == OP_LW ? MEMRD : Opcode == OP_SW ? MEMWR : FAULT;
      MEMRD:  nextState = MemReady ? MEMWB : MEMRD;
      MEMWR:  nextState = MemReady ? FETCH : MEMWR;
      EXEC:   nextState = ALUWB;
      ADDIEX: nextState = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: nextState = FETCH;
      FAULT:  nextState = FAULT;
      default: nextState = FAULT;
    endcase
    if (timedOut) nextState = FAULT;
    nextCause = timedOut ? 2'b10 : 2'b01;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      cause   <= 2'b00;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      if (nextState == FAULT && state != FAULT) cause <= nextCause;
      waitCnt <= nextState != state ? '0 : stalled ? waitCnt + CW'(1) : waitCnt;
    end
  end
  // Outputs decode from the state register but are gated by rst so nothing
  // reaches the datapath while reset is held.
  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; IRWrite = 1'b0; MemtoReg = 1'b0; RegDst = 1'b0;
    RegWrite = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 2'b00; ALUOp = 2'b00;
    PCSource = 2'b00; InstrDone = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1; ALUSrcB = 2'b01; IRWrite = MemReady; PCWrite = MemReady;
        end
        DECODE: ALUSrcB = 2'b11;
        MEMADR, ADDIEX: begin
          ALUSrcA = 1'b1; ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1; IorD = 1'b1;
        end
        MEMWB: begin
          MemtoReg = 1'b1; RegWrite = 1'b1; InstrDone = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1; IorD = 1'b1; InstrDone = MemReady;
        end
        EXEC: begin
          ALUSrcA = 1'b1; ALUOp = 2'b10;
        end
        ALUWB: begin
          RegDst = 1'b1; RegWrite = 1'b1; InstrDone = 1'b1;
        end
        BRANCH: begin
          ALUSrcA = 1'b1; ALUOp = 2'b01; PCWriteCond = 1'b1; PCSource = 2'b01; InstrDone = 1'b1;
        end
        JUMP: begin
          PCWrite = 1'b1; PCSource = 2'b10; InstrDone = 1'b1;
        end
        ADDIWB: begin
          RegWrite = 1'b1; InstrDone = 1'b1;
        end
        default: ;
      endcase
    end
    Fault      = !rst && state == FAULT;
    FaultCause = rst ? 2'b00 : cause;
    State      = rst ? 4'd0 : state;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle MIPS datapath: a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and write-back, one datapath phase per clock. It drives the shared ALU, register-file, memory and PC control lines, and stalls on a variable-latency memory ready handshake. It detects illegal opcodes and memory timeouts and parks in a sticky fault state. Supported instructions: R-type, lw, sw, beq, j, addi.

## Interface
- TIMEOUT_CYCLES, default 64: consecutive not-ready cycles allowed in a memory state before fault; 0 disables the timeout.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- Opcode  input  6  IR[31:26]; valid from DECODE onward
- MemReady  input  1  memory completed access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls
- ALUSrcB  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- ALUOp  output  2  00 add, 01 sub, 10 funct-decoded
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
- InstrDone  output  1  one-cycle pulse on the final cycle of an instruction
- Fault  output  1  sticky fault flag
- FaultCause  output  2  00 none, 01 illegal opcode, 10 memory timeout
- State  output  4  current state encoding, for debug

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, FAULT=15. All other codes go to FAULT with FaultCause=01.
- Outputs per state; any output not listed is 0:
  - FETCH: MemRead=1, ALUSrcB=01, IRWrite=MemReady, PCWrite=MemReady.
  - DECODE: ALUSrcB=11.
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDIWB: RegWrite=1.
- Transitions:
  - FETCH -> DECODE when MemReady=1.
  - DECODE dispatches on Opcode:
    - 000000 -> EXEC
    - 100011 and 101011 -> MEMADR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDIEX
    - other -> FAULT, cause 01
  - MEMADR -> MEMRD for lw, MEMWR for sw. Opcode is re-read here.
  - MEMRD -> MEMWB when MemReady=1.
  - MEMWR -> FETCH when MemReady=1.
  - EXEC -> ALUWB; ADDIEX -> ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
  - FAULT -> FAULT until reset.
- Memory states are FETCH, MEMRD and MEMWR. MemRead/MemWrite are held asserted until the cycle MemReady=1.
- InstrDone=1 in MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and in MEMWR when MemReady=1.
- Timeout counter:
  - Width clog2(TIMEOUT_CYCLES+1). Cleared on every state entry.
  - Increments each cycle a memory state sees MemReady=0.
  - When MemReady=0 and the count equals TIMEOUT_CYCLES-1, the next state is FAULT with cause 10.
- FAULT: Fault=1 and FaultCause held; all datapath controls 0.

## Timing
- While rst is high, the state register is FETCH, the counter is 0, and every output is forced to 0 combinationally. This includes MemRead, State=0, Fault=0, FaultCause=00.
- First FETCH cycle is the first rising edge after rst deasserts.
- Zero-wait memory (MemReady=1 constantly) cycle counts, FETCH through done: R=4, lw=5, sw=4, beq=3, j=3, addi=4.
- Each wait cycle in a memory state adds exactly one cycle.
- Memory ready on the timeout-boundary cycle: ready wins and the access completes normally.
- rst mid-instruction: immediate return to FETCH. No further RegWrite/MemWrite/PCWrite pulse after rst rises.
- FaultCause is latched on the transition into FAULT. It changes only on reset.
- PCWriteCond is a request only; the datapath ANDs it with ALU Zero.

## Test plan
- Reset then R-type (Opcode=000000, MemReady=1): State 0,1,6,7,0. RegWrite=1 and RegDst=1 only in cycle 4. InstrDone pulses once.
- lw with MemReady low for 3 cycles in MEMRD: State 0,1,2,3,3,3,3,4,0. MemRead and IorD high through all MEMRD cycles. Total 8 cycles.
- sw, beq, j, addi back-to-back with zero wait: sequence takes 4+3+3+4=14 cycles. BRANCH asserts PCWriteCond=1 with PCSource=01; JUMP asserts PCWrite=1 with PCSource=10.
- Opcode=111111 at DECODE: next state 15, Fault=1, FaultCause=01, all controls 0. State stays 15 for 20 further cycles, regardless of MemReady.
- TIMEOUT_CYCLES=4, MemReady=0 in FETCH: FETCH for 4 cycles, then FAULT with cause 10. Repeat with MemReady=1 on the 4th cycle: goes to DECODE with no fault.
- Assert rst during MEMWR (MemWrite=1): MemWrite drops to 0 the same cycle. After release, State=0 and a normal fetch follows.
